// File: rtl/blastit_pkg.sv
// Shared types and constants for the blastit serial front end.
package blastit_pkg;

  localparam int unsigned UART_OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } rx_state_t;

  // Clock cycles per sample tick, rounded to the nearest integer.
  function automatic int unsigned uart_div(input int unsigned clk_hz,
                                           input int unsigned baud,
                                           input int unsigned os);
    int unsigned den;
    den = baud * os;
    return (clk_hz + den / 2) / den;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Sample-tick divider; clr re-phases the count to a detected start edge.
module uart_baud_tick #(
  parameter int unsigned DIV = 27
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick_c
);

  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tick_c = (cnt == LAST);

endmodule

// File: rtl/uart_rx_frontend.sv
// 8N1 UART receiver: two-flop input sync, 16x oversampled framing with
// 3-sample majority vote, single-entry valid/ready holding register.
module uart_rx_frontend
  import blastit_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 50000000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned OVERSAMPLE = UART_OVERSAMPLE
) (
  input  logic       CLOCK_50,
  input  logic       RESET,
  input  logic       UART_RX,
  output logic [7:0] RX_DATA,
  output logic       RX_VALID,
  input  logic       RX_READY,
  output logic       FRAME_ERR,
  output logic       OVERRUN
);

  localparam int unsigned DIV   = uart_div(CLK_HZ, BAUD, OVERSAMPLE);
  localparam int unsigned IDX_W = $clog2(OVERSAMPLE);
  localparam logic [IDX_W-1:0] IDX_S0 = IDX_W'(7);
  localparam logic [IDX_W-1:0] IDX_S1 = IDX_W'(8);
  localparam logic [IDX_W-1:0] IDX_S2 = IDX_W'(9);

  logic             rx_meta;
  logic             rx_sync;
  rx_state_t        state;
  rx_state_t        state_nxt;
  logic [IDX_W-1:0] idx;
  logic [2:0]       bit_cnt;
  logic [7:0]       shift;
  logic             smp0;
  logic             smp1;
  logic             tick_c;
  logic             mid_c;
  logic             maj_c;
  logic             start_c;
  logic             shift_c;
  logic             done_c;
  logic             ferr_c;

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= UART_RX;
      rx_sync <= rx_meta;
    end
  end

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk    (CLOCK_50),
    .rst    (RESET),
    .clr    (start_c),
    .tick_c (tick_c)
  );

  // Decision point is the third sample; the first two were latched earlier.
  assign mid_c = tick_c && (idx == IDX_S2);
  assign maj_c = (smp0 & smp1) | (smp0 & rx_sync) | (smp1 & rx_sync);

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    start_c   = 1'b0;
    shift_c   = 1'b0;
    done_c    = 1'b0;
    ferr_c    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!rx_sync) begin
          state_nxt = ST_START;
          start_c   = 1'b1;
        end
      end
      ST_START: begin
        if (mid_c) begin
          state_nxt = maj_c ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (mid_c) begin
          shift_c = 1'b1;
          if (bit_cnt == 3'd7) begin
            state_nxt = ST_STOP;
          end
        end
      end
      ST_STOP: begin
        if (mid_c) begin
          if (maj_c) begin
            done_c    = 1'b1;
            state_nxt = ST_IDLE;
          end else begin
            ferr_c    = 1'b1;
            state_nxt = ST_BREAK;
          end
        end
      end
      ST_BREAK: begin
        if (rx_sync) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      idx     <= '0;
      bit_cnt <= '0;
      shift   <= '0;
      smp0    <= 1'b0;
      smp1    <= 1'b0;
    end else begin
      if (start_c) begin
        idx <= '0;
      end else if (tick_c) begin
        idx <= idx + IDX_W'(1);
      end
      if (tick_c && (idx == IDX_S0)) begin
        smp0 <= rx_sync;
      end
      if (tick_c && (idx == IDX_S1)) begin
        smp1 <= rx_sync;
      end
      if (start_c) begin
        bit_cnt <= '0;
      end else if (shift_c) begin
        bit_cnt <= bit_cnt + 3'd1;
      end
      if (shift_c) begin
        shift <= {maj_c, shift[7:1]};
      end
    end
  end

  // A completing byte may replace one being drained in the same cycle.
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      RX_DATA   <= '0;
      RX_VALID  <= 1'b0;
      FRAME_ERR <= 1'b0;
      OVERRUN   <= 1'b0;
    end else begin
      FRAME_ERR <= ferr_c;
      OVERRUN   <= 1'b0;
      if (done_c && (!RX_VALID || RX_READY)) begin
        RX_DATA  <= shift;
        RX_VALID <= 1'b1;
      end else if (done_c) begin
        OVERRUN <= 1'b1;
      end else if (RX_READY) begin
        RX_VALID <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_frontend.sv
// Scoreboard bench for uart_rx_frontend: a serial line model drives frames,
// expected bytes/pulses are queued, a negedge monitor pops and compares.
module tb_uart_rx_frontend;

  localparam real BIT_CYC = 432.0;
  localparam int  EV_FE   = 1;
  localparam int  EV_OV   = 2;

  logic       CLOCK_50 = 1'b0;
  logic       RESET;
  logic       UART_RX;
  logic       RX_READY;
  logic [7:0] RX_DATA;
  logic       RX_VALID;
  logic       FRAME_ERR;
  logic       OVERRUN;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;
  int byte_q[$];
  int evt_q[$];

  uart_rx_frontend dut (
    .CLOCK_50  (CLOCK_50),
    .RESET     (RESET),
    .UART_RX   (UART_RX),
    .RX_DATA   (RX_DATA),
    .RX_VALID  (RX_VALID),
    .RX_READY  (RX_READY),
    .FRAME_ERR (FRAME_ERR),
    .OVERRUN   (OVERRUN)
  );

  always #10 CLOCK_50 = ~CLOCK_50;
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLOCK_50);
      #1;
    end
  endtask

  // Line model: bit i occupies [i*bit_cyc, (i+1)*bit_cyc) cycles from frame start.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input real bit_cyc);
    logic [9:0] fr;
    int t0;
    fr = {stop_bit, b, 1'b0};
    t0 = cyc;
    for (int i = 0; i < 10; i++) begin
      UART_RX = fr[i];
      while (real'(cyc - t0) < real'(i + 1) * bit_cyc) step(1);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input real bit_cyc);
    byte_q.push_back(int'(b));
    send_frame(b, 1'b1, bit_cyc);
  endtask

  task automatic pop_evt(input int ev, input string name);
    if (evt_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: unexpected pulse at cycle %0d, none expected", name, cyc);
    end else begin
      check(name, ev, evt_q.pop_front());
    end
  endtask

  always @(negedge CLOCK_50) begin
    if (!RESET) begin
      if (FRAME_ERR && OVERRUN) begin
        checks++;
        errors++;
        $display("FAIL pulse_exclusive: FRAME_ERR and OVERRUN both 1, required at most one");
      end
      if (FRAME_ERR) pop_evt(EV_FE, "frame_err");
      if (OVERRUN) pop_evt(EV_OV, "overrun");
      if (RX_VALID && RX_READY) begin
        if (byte_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte: got 0x%02h, expected no byte (cycle %0d)", RX_DATA, cyc);
        end else begin
          check("rx_byte", int'(RX_DATA), byte_q.pop_front());
        end
      end
    end
  end

  initial begin
    int ts;
    RESET    = 1'b1;
    UART_RX  = 1'b1;
    RX_READY = 1'b0;
    step(5);
    check("reset_valid", int'(RX_VALID), 0);
    check("reset_data", int'(RX_DATA), 0);
    check("reset_ferr", int'(FRAME_ERR), 0);
    check("reset_ovr", int'(OVERRUN), 0);
    RESET = 1'b0;
    step(20);

    // Two nominal-rate bytes, consumer always ready
    RX_READY = 1'b1;
    send_byte(8'h55, BIT_CYC);
    send_byte(8'hA3, BIT_CYC);
    step(100);
    check("nominal_drained", byte_q.size(), 0);

    // Short low glitch on an idle line
    UART_RX = 1'b0;
    step(8);
    UART_RX = 1'b1;
    step(600);
    check("glitch_no_valid", int'(RX_VALID), 0);

    // Bad stop bit followed by a held-low break, then a clean byte
    evt_q.push_back(EV_FE);
    send_frame(8'h3C, 1'b0, BIT_CYC);
    step(4500);
    UART_RX = 1'b1;
    step(50);
    check("break_one_fe", evt_q.size(), 0);
    send_byte(8'h7E, BIT_CYC);
    step(100);
    check("after_break_drained", byte_q.size(), 0);

    // Overrun: consumer stalled for two bytes
    RX_READY = 1'b0;
    send_byte(8'h11, BIT_CYC);
    evt_q.push_back(EV_OV);
    send_frame(8'h22, 1'b1, BIT_CYC);
    step(50);
    check("ovr_valid_held", int'(RX_VALID), 1);
    check("ovr_data_kept", int'(RX_DATA), 8'h11);
    check("ovr_pulse_seen", evt_q.size(), 0);
    RX_READY = 1'b1;
    step(1);
    RX_READY = 1'b0;
    check("ovr_valid_drop", int'(RX_VALID), 0);
    check("ovr_drained", byte_q.size(), 0);

    // Drain in exactly the completion cycle of the next byte
    send_byte(8'h11, BIT_CYC);
    byte_q.push_back(8'h22);
    ts = cyc;
    fork
      send_frame(8'h22, 1'b1, BIT_CYC);
      begin
        while (cyc < ts + 4160) step(1);
        RX_READY = 1'b1;
        step(1);
        RX_READY = 1'b0;
      end
    join
    step(20);
    check("same_cycle_valid", int'(RX_VALID), 1);
    check("same_cycle_data", int'(RX_DATA), 8'h22);
    check("same_cycle_no_ovr", evt_q.size(), 0);
    RX_READY = 1'b1;
    step(2);
    check("same_cycle_drained", byte_q.size(), 0);

    // Sender at +3% and -3% rate, extreme data, back to back
    send_byte(8'h00, BIT_CYC / 1.03);
    send_byte(8'hFF, BIT_CYC / 1.03);
    send_byte(8'h00, BIT_CYC / 0.97);
    send_byte(8'hFF, BIT_CYC / 0.97);
    step(100);
    check("skew_drained", byte_q.size(), 0);

    // Random bytes at random rate error within tolerance
    for (int k = 0; k < 2; k++) begin
      logic [7:0] b;
      real f;
      b = 8'($urandom_range(0, 255));
      f = 0.97 + real'($urandom_range(0, 600)) / 10000.0;
      send_byte(b, BIT_CYC / f);
      step(int'($urandom_range(0, 40)));
    end
    step(100);
    check("random_drained", byte_q.size(), 0);

    // Reset mid-frame while a byte is held
    RX_READY = 1'b0;
    send_byte(8'h99, BIT_CYC);
    step(20);
    check("pre_reset_valid", int'(RX_VALID), 1);
    UART_RX = 1'b0;
    step(1000);
    UART_RX = 1'b1;
    step(500);
    UART_RX = 1'b0;
    step(300);
    RESET = 1'b1;
    step(1);
    check("midreset_valid", int'(RX_VALID), 0);
    check("midreset_data", int'(RX_DATA), 0);
    check("midreset_ferr", int'(FRAME_ERR), 0);
    check("midreset_ovr", int'(OVERRUN), 0);
    byte_q.delete();
    evt_q.delete();
    UART_RX = 1'b1;
    step(3);
    RESET = 1'b0;
    step(10);
    RX_READY = 1'b1;
    send_byte(8'h4B, BIT_CYC);
    step(100);

    check("final_bytes_empty", byte_q.size(), 0);
    check("final_events_empty", evt_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
